// File: rtl/bus_initiator.sv
// rtl/bus_initiator.sv - burst bus initiator with request/grant handshake
//
// Purpose: accepts a local burst command, requests the bus, drives
// frame/irdy for cmd_len+1 beats, then idles the bus for one turnaround
// cycle. A grant lost mid-burst drops frame/irdy and re-requests the bus,
// keeping the remaining beat count.
//
// Optional feature: define BUS_INIT_TIMEOUT_EN to abort a request after
// TMO_CYC consecutive cycles without grant (tmo_err pulse, command dropped).
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   cmd_valid  in   burst command valid
//   cmd_len    in   burst beats minus one
//   cmd_ready  out  command accepted when cmd_valid && cmd_ready
//   gnt_n      in   active-low grant from the arbiter
//   trdy       in   target ready; beat completes on irdy && trdy
//   req_n      out  active-low bus request
//   frame      out  transaction in progress
//   irdy       out  initiator ready
//   xfer_done  out  one-cycle pulse after the final beat
//   tmo_err    out  one-cycle pulse on grant timeout
module bus_initiator #(
   parameter int LEN_W   = 4,
   parameter int TMO_CYC = 15
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cmd_valid,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             cmd_ready,
   input  logic             gnt_n,
   input  logic             trdy,
   output logic             req_n,
   output logic             frame,
   output logic             irdy,
   output logic             xfer_done,
   output logic             tmo_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_XFER = 2'd2,
      S_TURN = 2'd3
   } state_t;

   state_t           r_state;
   logic [LEN_W-1:0] r_cnt;
   logic             r_cmd_ready;
   logic             r_req_n;
   logic             r_frame;
   logic             r_irdy;
   logic             r_xfer_done;

   logic             w_accept;
   logic             w_beat;
   logic             w_last;

   assign w_accept = cmd_valid && r_cmd_ready;
   assign w_beat   = r_irdy && trdy;
   // r_cnt holds beats remaining minus one, so zero means this is the final beat
   assign w_last   = w_beat && (r_cnt == '0);

`ifdef BUS_INIT_TIMEOUT_EN
   localparam int TMO_W = $clog2(TMO_CYC + 1);

   logic [TMO_W-1:0] r_wait;
   logic             r_tmo_err;
   logic             w_tmo;

   // r_wait counts earlier ungranted REQ cycles; this one is the TMO_CYC-th
   assign w_tmo   = gnt_n && (r_wait == TMO_W'(TMO_CYC - 1));
   assign tmo_err = r_tmo_err;
`else
   // TMO_CYC only matters with the timeout built; the term below is always 0
   assign tmo_err = 1'b0 & (TMO_CYC == 0);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_cmd_ready <= 1'b0;
         r_req_n     <= 1'b1;
         r_frame     <= 1'b0;
         r_irdy      <= 1'b0;
         r_xfer_done <= 1'b0;
`ifdef BUS_INIT_TIMEOUT_EN
         r_wait      <= '0;
         r_tmo_err   <= 1'b0;
`endif
      end else begin
         r_xfer_done <= 1'b0;
`ifdef BUS_INIT_TIMEOUT_EN
         r_tmo_err   <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state     <= S_REQ;
                  r_cnt       <= cmd_len;
                  r_cmd_ready <= 1'b0;
                  r_req_n     <= 1'b0;
`ifdef BUS_INIT_TIMEOUT_EN
                  r_wait      <= '0;
`endif
               end else begin
                  // first cycle out of reset raises cmd_ready here
                  r_cmd_ready <= 1'b1;
               end
            end
            S_REQ: begin
               if (!gnt_n) begin
                  r_state <= S_XFER;
                  r_frame <= 1'b1;
                  r_irdy  <= 1'b1;
               end
`ifdef BUS_INIT_TIMEOUT_EN
               else if (w_tmo) begin
                  r_state     <= S_IDLE;
                  r_req_n     <= 1'b1;
                  r_cmd_ready <= 1'b1;
                  r_tmo_err   <= 1'b1;
                  r_cnt       <= '0;
               end else begin
                  r_wait <= r_wait + TMO_W'(1);
               end
`endif
            end
            S_XFER: begin
               if (w_last) begin
                  r_state     <= S_TURN;
                  r_xfer_done <= 1'b1;
                  r_req_n     <= 1'b1;
                  r_frame     <= 1'b0;
                  r_irdy      <= 1'b0;
               end else begin
                  if (w_beat) begin
                     r_cnt <= r_cnt - LEN_W'(1);
                  end
                  // grant lost with beats left: back off and re-request
                  if (gnt_n) begin
                     r_state <= S_REQ;
                     r_frame <= 1'b0;
                     r_irdy  <= 1'b0;
`ifdef BUS_INIT_TIMEOUT_EN
                     r_wait  <= '0;
`endif
                  end
               end
            end
            S_TURN: begin
               r_state     <= S_IDLE;
               r_cmd_ready <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign req_n     = r_req_n;
   assign frame     = r_frame;
   assign irdy      = r_irdy;
   assign xfer_done = r_xfer_done;

endmodule

// File: tb/tb_bus_initiator.sv
// tb/tb_bus_initiator.sv - self-checking bench for bus_initiator
module tb_bus_initiator;

   logic       clk       = 1'b0;
   logic       reset_n   = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [3:0] cmd_len   = 4'd0;
   logic       gnt_n     = 1'b1;
   logic       trdy      = 1'b0;
   logic       cmd_ready;
   logic       req_n;
   logic       frame;
   logic       irdy;
   logic       xfer_done;
   logic       tmo_err;

   int n_pass  = 0;
   int n_total = 0;

   // transaction-level reference state
   bit busy = 1'b0;
   int left = 0;

   typedef struct {
      logic       cv;
      logic [3:0] len;
      logic       gnt_n;
      logic       trdy;
      logic [4:0] exp;   // {cmd_ready, req_n, frame, irdy, xfer_done}
   } vec_t;

   vec_t tbl[12];

   always #5 clk = ~clk;

   bus_initiator dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmd_valid (cmd_valid),
      .cmd_len   (cmd_len),
      .cmd_ready (cmd_ready),
      .gnt_n     (gnt_n),
      .trdy      (trdy),
      .req_n     (req_n),
      .frame     (frame),
      .irdy      (irdy),
      .xfer_done (xfer_done),
      .tmo_err   (tmo_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_len   = 4'd0;
      gnt_n     = 1'b1;
      trdy      = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      reset_n = 1'b1;
   endtask

   // one clock of random traffic scored against beat/command bookkeeping
   task automatic model_cycle();
      logic p_acc, p_beat, p_frame, p_gnt, p_req, exp_done;
      logic [3:0] p_len;
      p_acc   = cmd_valid && cmd_ready;
      p_beat  = irdy && trdy;
      p_frame = frame;
      p_gnt   = gnt_n;
      p_req   = req_n;
      p_len   = cmd_len;
      step();
      exp_done = 1'b0;
      if (p_acc) begin
         chk("rnd_accept_when_idle", 32'(busy), 0);
         busy = 1'b1;
         left = int'(p_len) + 1;
      end
      if (p_beat) begin
         chk("rnd_beat_when_busy", 32'(busy), 1);
         if (left > 0) left--;
         if (busy && left == 0) begin
            exp_done = 1'b1;
            busy     = 1'b0;
         end
      end
      chk("rnd_xfer_done", 32'(xfer_done), 32'(exp_done));
      chk("rnd_cmd_ready", 32'(cmd_ready), 32'(!busy && !exp_done));
      chk("rnd_req_n", 32'(req_n), 32'(!busy));
      chk("rnd_frame_eq_irdy", 32'(frame), 32'(irdy));
      chk("rnd_tmo_err", 32'(tmo_err), 0);
      if (frame && !p_frame) chk("rnd_grant_before_frame", 32'({p_req, p_gnt}), 0);
      if (!frame && p_frame && !xfer_done) chk("rnd_retry_on_gnt_loss", 32'(p_gnt), 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int beats, beats2, xcyc, dones, bad;
      bit seen;

      tbl[0]  = '{1'b1, 4'd3, 1'b1, 1'b0, 5'b11000};
      tbl[1]  = '{1'b1, 4'd3, 1'b1, 1'b0, 5'b00000};
      tbl[2]  = '{1'b1, 4'd3, 1'b1, 1'b0, 5'b00000};
      tbl[3]  = '{1'b1, 4'd3, 1'b0, 1'b0, 5'b00110};
      tbl[4]  = '{1'b1, 4'd3, 1'b0, 1'b1, 5'b00110};
      tbl[5]  = '{1'b1, 4'd3, 1'b0, 1'b1, 5'b00110};
      tbl[6]  = '{1'b1, 4'd3, 1'b0, 1'b1, 5'b00110};
      tbl[7]  = '{1'b1, 4'd3, 1'b0, 1'b1, 5'b01001};
      tbl[8]  = '{1'b1, 4'd3, 1'b1, 1'b0, 5'b11000};
      tbl[9]  = '{1'b1, 4'd3, 1'b1, 1'b0, 5'b00000};
      tbl[10] = '{1'b0, 4'd3, 1'b0, 1'b0, 5'b00110};
      tbl[11] = '{1'b0, 4'd3, 1'b0, 1'b1, 5'b00110};

      // reset values while clocks run
      #12;
      chk("reset_outputs", 32'({cmd_ready, req_n, frame, irdy, xfer_done, tmo_err}), 32'(6'b010000));

      // 4-beat burst, late grant, cmd_valid held across the burst
      apply_reset();
      for (int i = 0; i < 12; i++) begin
         cmd_valid = tbl[i].cv;
         cmd_len   = tbl[i].len;
         gnt_n     = tbl[i].gnt_n;
         trdy      = tbl[i].trdy;
         step();
         chk($sformatf("vec%0d", i), 32'({cmd_ready, req_n, frame, irdy, xfer_done}), 32'(tbl[i].exp));
      end

      // asynchronous reset mid-XFER
      #3;
      reset_n = 1'b0;
      #1;
      chk("async_rst_now", 32'({req_n, frame, irdy, cmd_ready, xfer_done}), 32'(5'b10000));
      step();
      chk("async_rst_held", 32'({req_n, frame, irdy, cmd_ready, xfer_done}), 32'(5'b10000));
      #3;
      reset_n = 1'b1;
      trdy    = 1'b0;
      dones   = 0;
      step();
      chk("rst_release_ready", 32'(cmd_ready), 1);
      if (xfer_done) dones++;
      repeat (5) begin
         step();
         if (xfer_done) dones++;
      end
      chk("rst_no_done", 32'(dones), 0);

      // 16-beat burst, trdy every other XFER cycle
      apply_reset();
      cmd_valid = 1'b1;
      cmd_len   = 4'd15;
      step();
      step();
      cmd_valid = 1'b0;
      gnt_n     = 1'b0;
      step();
      xcyc  = 0;
      beats = 0;
      seen  = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (frame) xcyc++;
         trdy = (xcyc % 2 == 0);
         if (irdy && trdy) beats++;
         step();
         if (xfer_done) begin
            seen = 1'b1;
            break;
         end
      end
      chk("b16_done_seen", 32'(seen), 1);
      chk("b16_beats", beats, 16);
      chk("b16_xfer_cycles", xcyc, 32);
      chk("b16_turn_bus_idle", 32'({req_n, frame, irdy, cmd_ready}), 32'(4'b1000));
      trdy = 1'b0;
      step();
      chk("b16_idle_after_turn", 32'({cmd_ready, xfer_done}), 32'(2'b10));

      // grant lost after beat 2 of 6, re-grant completes remaining 4
      apply_reset();
      cmd_valid = 1'b1;
      cmd_len   = 4'd5;
      step();
      step();
      cmd_valid = 1'b0;
      gnt_n     = 1'b0;
      trdy      = 1'b1;
      step();
      beats = 0;
      for (int k = 0; k < 10; k++) begin
         if (irdy && trdy) beats++;
         step();
         if (beats == 2) break;
      end
      chk("retry_first_beats", beats, 2);
      gnt_n = 1'b1;
      trdy  = 1'b0;
      step();
      chk("retry_back_to_req", 32'({req_n, frame, irdy}), 32'(3'b000));
      step();
      chk("retry_waits_grant", 32'({req_n, frame, irdy}), 32'(3'b000));
      gnt_n  = 1'b0;
      trdy   = 1'b1;
      beats2 = 0;
      dones  = 0;
      for (int k = 0; k < 20; k++) begin
         if (irdy && trdy) beats2++;
         step();
         if (xfer_done) dones++;
      end
      chk("retry_remaining_beats", beats2, 4);
      chk("retry_single_done", dones, 1);

      // long grant wait
      apply_reset();
      cmd_valid = 1'b1;
      cmd_len   = 4'd0;
      step();
      step();
      cmd_valid = 1'b0;
      gnt_n     = 1'b1;
`ifdef BUS_INIT_TIMEOUT_EN
      bad = 0;
      for (int k = 1; k <= 15; k++) begin
         step();
         if (k < 15 && (tmo_err !== 1'b0 || req_n !== 1'b0)) bad++;
      end
      chk("tmo_quiet_before", bad, 0);
      chk("tmo_pulse", 32'({tmo_err, req_n, cmd_ready, xfer_done}), 32'(4'b1110));
      step();
      chk("tmo_idle_next", 32'({tmo_err, cmd_ready, req_n}), 32'(3'b011));
`else
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (req_n !== 1'b0 || tmo_err !== 1'b0 || frame !== 1'b0) bad++;
      end
      chk("no_tmo_wait", bad, 0);
`endif

      // randomized traffic against the transaction model
      apply_reset();
      step();
      busy = 1'b0;
      left = 0;
      for (int k = 0; k < 400; k++) begin
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_len   = 4'($urandom_range(0, 15));
         gnt_n     = ($urandom_range(0, 3) == 0);
         trdy      = 1'($urandom_range(0, 1));
         model_cycle();
      end
      cmd_valid = 1'b0;
      gnt_n     = 1'b0;
      trdy      = 1'b1;
      for (int k = 0; k < 80; k++) begin
         if (!busy && !xfer_done) break;
         model_cycle();
      end
      chk("rnd_drained", 32'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/bus_initiator.md
BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 The block SHALL have parameter LEN_W, default 4, meaning width of the burst-length field.
REQ-002 The block SHALL have parameter TMO_CYC, default 15, meaning grant-wait timeout in cycles (used only when BUS_INIT_TIMEOUT_EN is defined).
REQ-003 The block SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port cmd_valid  in  1  local burst command valid.
REQ-006 The block SHALL have port cmd_len  in  LEN_W  burst beats minus one; 0 = 1 beat, 15 = 16 beats.
REQ-007 The block SHALL have port cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-008 The block SHALL have port gnt_n  in  1  active-low grant from the bus arbiter.
REQ-009 The block SHALL have port trdy  in  1  target ready; a beat completes on a cycle with irdy && trdy.
REQ-010 The block SHALL have port req_n  out  1  active-low bus request to the arbiter.
REQ-011 The block SHALL have port frame  out  1  transaction-in-progress qualifier.
REQ-012 The block SHALL have port irdy  out  1  initiator ready.
REQ-013 The block SHALL have port xfer_done  out  1  one-cycle pulse when the final beat completes.
REQ-014 The block SHALL have port tmo_err  out  1  one-cycle pulse on grant timeout (tied 0 without the macro).

Function
REQ-015 The block SHALL implement the states IDLE, REQ, XFER and TURN; all outputs are registered.
REQ-016 In IDLE, cmd_ready SHALL be 1; all other states SHALL drive cmd_ready 0.
REQ-017 On cmd_valid && cmd_ready, the block SHALL latch cmd_len into the remaining-beat counter and enter REQ next cycle.
REQ-018 In REQ, req_n SHALL be 0 and frame and irdy SHALL be 0.
REQ-019 In REQ, sampling gnt_n==0 SHALL move the block to XFER next cycle, i.e. frame and irdy assert 1 cycle after the grant is seen.
REQ-020 In XFER, frame, irdy SHALL be 1 and req_n SHALL stay 0.
REQ-021 In XFER, each cycle with trdy==1 SHALL decrement the remaining-beat counter; trdy==0 SHALL hold it (wait state).
REQ-022 A beat completing with counter==0 SHALL pulse xfer_done, deassert frame, irdy and req_n (req_n=1) next cycle, and enter TURN.
REQ-023 TURN SHALL last exactly 1 cycle with all bus outputs idle (req_n=1, frame=0, irdy=0), then return to IDLE.
REQ-024 If gnt_n==1 is sampled in XFER with beats remaining and no beat completing that cycle, the block SHALL drop frame and irdy, keep the remaining count, and return to REQ (retry).
REQ-025 If a beat completes and gnt_n==1 is sampled in the same cycle, the beat SHALL count; a retry to REQ occurs only if beats remain.
REQ-026 The counter SHALL be LEN_W bits, SHALL never wrap below 0, and a 16-beat burst (cmd_len=15) SHALL complete exactly 16 beats.
REQ-027 xfer_done and tmo_err SHALL never assert in the same cycle.

Reset
REQ-028 While reset_n==0, regardless of clk, the block SHALL be in IDLE with req_n=1, frame=0, irdy=0, cmd_ready=0, xfer_done=0, tmo_err=0, and counters=0.
REQ-029 cmd_ready SHALL rise on the first clk edge after reset_n deasserts.
REQ-030 Reset asserted mid-burst SHALL abort immediately with no xfer_done pulse.

Configuration
REQ-031 With BUS_INIT_TIMEOUT_EN defined, a wait-cycle counter SHALL run in REQ; TMO_CYC consecutive cycles of gnt_n==1 SHALL pulse tmo_err, drop req_n and return to IDLE, discarding the command.
REQ-032 With BUS_INIT_TIMEOUT_EN defined, the wait-cycle counter SHALL clear on entry to REQ, including retry entries.
REQ-033 Without BUS_INIT_TIMEOUT_EN, the block SHALL wait indefinitely in REQ, tmo_err SHALL be constant 0, and no timeout counter SHALL be built.

Verification
REQ-034 The bench SHALL cover: cmd_len=3, gnt_n low 2 cycles after req_n falls, trdy=1 -> exactly 4 beats, xfer_done pulse on beat 4, req_n=1 the next cycle, 1 TURN cycle.
REQ-035 The bench SHALL cover: cmd_len=15 with trdy toggling every other cycle -> 16 beats over 32 XFER cycles, counter never wraps.
REQ-036 The bench SHALL cover: gnt_n rises after beat 2 of a 6-beat burst -> frame=0, REQ re-entered, remaining 4 beats complete after re-grant, single xfer_done.
REQ-037 The bench SHALL cover: BUS_INIT_TIMEOUT_EN with TMO_CYC=15 and gnt_n held 1 -> tmo_err pulses on cycle 15 of REQ, IDLE next, cmd_ready=1.
REQ-038 The bench SHALL cover: reset_n pulsed low mid-XFER between clock edges -> req_n=1, frame=0 immediately, no xfer_done.
REQ-039 The bench SHALL cover: cmd_valid held during a burst -> no second accept until IDLE, then accepted the cycle after TURN.
